aurora_tx_arbiter: RTL and testbench
====================================

Name: aurora_tx_arbiter

Overview:
- Packet-granular round-robin arbiter sharing the single Aurora 64B/66B framing TX interface between two LocalLink-style requesters (ch0, ch1).
- Sits between user packet sources and the Aurora core TX port, in the USER_CLK domain.
- Gates all traffic on CHANNEL_UP and reports protocol and over-length errors.

Parameters:
MAX_PKT_BEATS, 256, max accepted beats per packet; a beat count reaching this without EOP raises ERR_LEN
BEAT_CNT_W, 9, beat counter width; must hold MAX_PKT_BEATS

Ports:
USER_CLK  in  1  Aurora user clock; all logic on rising edge
RESET  in  1  asynchronous, active-high reset
CHANNEL_UP  in  1  Aurora channel status
ch0_data_i  in  [0:63]  requester 0 data
ch0_sop_n_i  in  1  requester 0 start of packet, active low
ch0_eop_n_i  in  1  requester 0 end of packet, active low
ch0_mod_i  in  [0:2]  requester 0 valid-byte remainder on EOP beat
ch0_src_rdy_n_i  in  1  requester 0 beat valid, active low
ch0_dst_rdy_n_o  out  1  requester 0 beat accepted, active low
ch1_*  same five inputs and one output as ch0, for requester 1
txdata_o  out  [0:63]  to Aurora TX data
txdata_sop_n_o  out  1  to Aurora TX
txdata_eop_n_o  out  1  to Aurora TX
txdata_mod_o  out  [0:2]  to Aurora TX
tx_src_rdy_n_o  out  1  to Aurora TX
tx_dst_rdy_n_i  in  1  from Aurora TX, active low
grant_o  out  [1:0]  one-hot current owner; 00 = idle
ERR_ABORT  out  1  one-cycle pulse: packet aborted by CHANNEL_UP loss
ERR_LEN  out  1  one-cycle pulse: MAX_PKT_BEATS reached without EOP

Behaviour:
- FSM states: IDLE, GNT0, GNT1. State, last_owner, beat_cnt and error pulses are registered. Datapath mux and ready routing are combinational from state.
- Reset (async assert; release synchronous to USER_CLK):
  - state=IDLE, last_owner=1 so ch0 wins first, beat_cnt=0.
  - All *_n outputs=1, txdata_o=0, txdata_mod_o=0, grant_o=00, ERR_*=0.
- Request definition: chX_req = !chX_src_rdy_n_i & !chX_sop_n_i & CHANNEL_UP.
- IDLE:
  - Outputs driven to reset values; both chX_dst_rdy_n_o=1.
  - One request: go to that GNTx next cycle.
  - Both requesting: grant the channel != last_owner.
  - Arbitration latency is 1 cycle (IDLE -> GNTx); no beat is accepted in IDLE.
- GNTx:
  - Aurora TX outputs = chX inputs.
  - chX_dst_rdy_n_o = tx_dst_rdy_n_i; the other channel's dst_rdy_n_o=1.
  - grant_o one-hot for X; last_owner<=X on entry.
  - Beat transfer = !chX_src_rdy_n_i & !tx_dst_rdy_n_i.
  - On each transfer beat_cnt increments; it is cleared on entry to IDLE.
- Exit from GNTx:
  - Transfer with eop_n=0: next state IDLE. There is always one idle cycle between packets.
  - A single-beat packet (sop and eop on the same beat) is legal.
- CHANNEL_UP falls while in GNTx:
  - Same cycle: tx_src_rdy_n_o forced 1 and chX_dst_rdy_n_o forced 1.
  - Next cycle: state IDLE and ERR_ABORT pulses 1 cycle.
  - Remaining beats of the aborted packet wait at the requester until it drops them.
  - Because arbitration requires sop, mid-packet beats are never granted.
- beat_cnt reaching MAX_PKT_BEATS on a non-EOP transfer:
  - ERR_LEN pulses 1 cycle.
  - Grant is held until EOP and the counter saturates.
- Mid-packet sop_n=0 from the owner is passed through unchanged; it is not checked.
- Simultaneous EOP transfer and CHANNEL_UP fall: the packet counts as complete and there is no ERR_ABORT.

Optional Feature:
ARB_STRICT_PRIO_EN:
- Defined: ch0 has strict priority. When both channels request in IDLE, ch0 is always granted and last_owner is ignored. Grants remain packet-granular.
- Undefined: round-robin as above.

Test Plan:
- CHANNEL_UP=1, ch0 sends a 4-beat packet with tx_dst_rdy_n_i=0 -> grant_o=01 one cycle after the request; 4 beats appear on txdata_o with sop on beat 1, eop plus mod on beat 4; then IDLE, grant_o=00.
- Both channels request continuously with 2-beat packets -> grants alternate 01,10,01,10 with one idle cycle between packets. With ARB_STRICT_PRIO_EN -> always 01.
- Owner ch1 mid-packet, tx_dst_rdy_n_i toggles 0/1 every cycle -> ch1_dst_rdy_n_o mirrors it; ch0_dst_rdy_n_o stays 1; no beat is lost or duplicated.
- CHANNEL_UP drops after beat 2 of a 5-beat packet -> tx_src_rdy_n_o=1 the same cycle, ERR_ABORT pulses 1 cycle, state IDLE; no further grants while CHANNEL_UP=0.
- MAX_PKT_BEATS=8, 10-beat packet -> ERR_LEN pulse on the 8th transfer; beats 9-10 still pass; released at EOP.
- RESET asserted mid-packet -> all *_n outputs 1 and grant_o=00 immediately (async); after release, ch0 wins the first simultaneous request.

Source files
------------

// File: rtl/aurora_tx_arbiter.sv
// Packet-granular ch0/ch1 arbiter onto one Aurora TX port: grant 1 cycle after sop request, combinational datapath.
// Only the owner sees tx_dst_rdy_n_i, CHANNEL_UP loss blocks both; define ARB_STRICT_PRIO_EN for ch0 strict priority.
module aurora_tx_arbiter #(
  parameter int MAX_PKT_BEATS = 256,
  parameter int BEAT_CNT_W    = 9
) (
  input  logic        USER_CLK,
  input  logic        RESET,
  input  logic        CHANNEL_UP,
  input  logic [0:63] ch0_data_i,
  input  logic        ch0_sop_n_i,
  input  logic        ch0_eop_n_i,
  input  logic [0:2]  ch0_mod_i,
  input  logic        ch0_src_rdy_n_i,
  output logic        ch0_dst_rdy_n_o,
  input  logic [0:63] ch1_data_i,
  input  logic        ch1_sop_n_i,
  input  logic        ch1_eop_n_i,
  input  logic [0:2]  ch1_mod_i,
  input  logic        ch1_src_rdy_n_i,
  output logic        ch1_dst_rdy_n_o,
  output logic [0:63] txdata_o,
  output logic        txdata_sop_n_o,
  output logic        txdata_eop_n_o,
  output logic [0:2]  txdata_mod_o,
  output logic        tx_src_rdy_n_o,
  input  logic        tx_dst_rdy_n_i,
  output logic [1:0]  grant_o,
  output logic        ERR_ABORT,
  output logic        ERR_LEN
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_e;

  typedef struct packed {
    logic [0:63] data;
    logic        sop_n;
    logic        eop_n;
    logic [0:2]  mod;
    logic        src_rdy_n;
  } beat_t;

  localparam logic [BEAT_CNT_W-1:0] CNT_MAX  = BEAT_CNT_W'(MAX_PKT_BEATS);
  localparam logic [BEAT_CNT_W-1:0] CNT_LAST = BEAT_CNT_W'(MAX_PKT_BEATS - 1);

  state_e                state_q;
  logic                  last_owner_q;
  logic [BEAT_CNT_W-1:0] beat_cnt_q;
  logic [BEAT_CNT_W-1:0] beat_cnt_d;
  logic                  err_abort_q;
  logic                  err_len_q;

  beat_t ch0_beat;
  beat_t ch1_beat;
  beat_t own_beat;
  logic  ch0_req;
  logic  ch1_req;
  logic  ch0_wins;
  logic  granted;
  logic  xfer;

  assign ch0_beat = '{data: ch0_data_i, sop_n: ch0_sop_n_i, eop_n: ch0_eop_n_i,
                      mod: ch0_mod_i, src_rdy_n: ch0_src_rdy_n_i};
  assign ch1_beat = '{data: ch1_data_i, sop_n: ch1_sop_n_i, eop_n: ch1_eop_n_i,
                      mod: ch1_mod_i, src_rdy_n: ch1_src_rdy_n_i};

  // Only a sop beat can request, so an aborted packet's tail is never granted.
  assign ch0_req = ~ch0_src_rdy_n_i & ~ch0_sop_n_i & CHANNEL_UP;
  assign ch1_req = ~ch1_src_rdy_n_i & ~ch1_sop_n_i & CHANNEL_UP;

`ifdef ARB_STRICT_PRIO_EN
  assign ch0_wins = 1'b1;
`else
  assign ch0_wins = last_owner_q;
`endif

  assign granted    = (state_q != IDLE);
  assign own_beat   = (state_q == GNT1) ? ch1_beat : ch0_beat;
  assign xfer       = granted & ~own_beat.src_rdy_n & ~tx_dst_rdy_n_i;
  assign beat_cnt_d = (beat_cnt_q == CNT_MAX) ? beat_cnt_q : beat_cnt_q + 1'b1;

  always_comb begin
    txdata_o        = '0;
    txdata_sop_n_o  = 1'b1;
    txdata_eop_n_o  = 1'b1;
    txdata_mod_o    = '0;
    tx_src_rdy_n_o  = 1'b1;
    ch0_dst_rdy_n_o = 1'b1;
    ch1_dst_rdy_n_o = 1'b1;
    grant_o         = 2'b00;
    if (granted) begin
      txdata_o       = own_beat.data;
      txdata_sop_n_o = own_beat.sop_n;
      txdata_eop_n_o = own_beat.eop_n;
      txdata_mod_o   = own_beat.mod;
      tx_src_rdy_n_o = own_beat.src_rdy_n | ~CHANNEL_UP;
      grant_o        = (state_q == GNT1) ? 2'b10 : 2'b01;
    end
    if (state_q == GNT0) ch0_dst_rdy_n_o = tx_dst_rdy_n_i | ~CHANNEL_UP;
    if (state_q == GNT1) ch1_dst_rdy_n_o = tx_dst_rdy_n_i | ~CHANNEL_UP;
  end

  always_ff @(posedge USER_CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      beat_cnt_q   <= '0;
      err_abort_q  <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      err_abort_q <= 1'b0;
      err_len_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          beat_cnt_q <= '0;
          if (ch0_req && (!ch1_req || ch0_wins)) begin
            state_q      <= GNT0;
            last_owner_q <= 1'b0;
          end else if (ch1_req) begin
            state_q      <= GNT1;
            last_owner_q <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (xfer) beat_cnt_q <= beat_cnt_d;
          // A completed EOP wins over a simultaneous link drop.
          if (xfer && !own_beat.eop_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
          end else if (!CHANNEL_UP) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            err_abort_q <= 1'b1;
          end else if (xfer && beat_cnt_q == CNT_LAST) begin
            err_len_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ERR_ABORT = err_abort_q;
  assign ERR_LEN   = err_len_q;

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Bench for aurora_tx_arbiter: directed abort/length/reset cases plus random packet streams
// checked against a packet-order model (round robin, or ch0-first when ARB_STRICT_PRIO_EN).
module tb_aurora_tx_arbiter;
  localparam int MAXB = 8;
  localparam int NP   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cup;
  logic [0:63] c0_dat, c1_dat;
  logic        c0_sop_n, c0_eop_n, c0_src_n, c0_dst_n;
  logic        c1_sop_n, c1_eop_n, c1_src_n, c1_dst_n;
  logic [0:2]  c0_mod, c1_mod;
  logic [0:63] tx_dat;
  logic        tx_sop_n, tx_eop_n, tx_src_n, tx_dst_n;
  logic [0:2]  tx_mod;
  logic [1:0]  grant;
  logic        err_abort, err_len;

  int          checks = 0;
  int          fails  = 0;
  logic [63:0] pdata [2][NP][NP];
  int          plen  [2][NP];
  logic [2:0]  pmod  [2][NP];
  int          np    [2];
  int          order [$];

  always #5 clk = ~clk;

  aurora_tx_arbiter #(.MAX_PKT_BEATS(MAXB), .BEAT_CNT_W(4)) dut (
    .USER_CLK(clk), .RESET(rst), .CHANNEL_UP(cup),
    .ch0_data_i(c0_dat), .ch0_sop_n_i(c0_sop_n), .ch0_eop_n_i(c0_eop_n),
    .ch0_mod_i(c0_mod), .ch0_src_rdy_n_i(c0_src_n), .ch0_dst_rdy_n_o(c0_dst_n),
    .ch1_data_i(c1_dat), .ch1_sop_n_i(c1_sop_n), .ch1_eop_n_i(c1_eop_n),
    .ch1_mod_i(c1_mod), .ch1_src_rdy_n_i(c1_src_n), .ch1_dst_rdy_n_o(c1_dst_n),
    .txdata_o(tx_dat), .txdata_sop_n_o(tx_sop_n), .txdata_eop_n_o(tx_eop_n),
    .txdata_mod_o(tx_mod), .tx_src_rdy_n_o(tx_src_n), .tx_dst_rdy_n_i(tx_dst_n),
    .grant_o(grant), .ERR_ABORT(err_abort), .ERR_LEN(err_len)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drv(input int ch, input logic [63:0] d, input bit sop, input bit eop,
                     input logic [2:0] m, input bit vld);
    if (ch == 0) begin
      c0_dat = d; c0_sop_n = ~sop; c0_eop_n = ~eop; c0_mod = m; c0_src_n = ~vld;
    end else begin
      c1_dat = d; c1_sop_n = ~sop; c1_eop_n = ~eop; c1_mod = m; c1_src_n = ~vld;
    end
  endtask

  task automatic quiet();
    drv(0, 64'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    drv(1, 64'd0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  // Sources present their next sop immediately, so every packet boundary is exactly one idle cycle
  // and the grant sequence is fixed by the arbitration rule alone.
  task automatic run_pkts(input int first, input bit rnd);
    int opk [2];
    int bi [2];
    int pi [2];
    int cnt [2];
    int a, eidx, ebeat, own, pk, exp_el, el_seen, ab_seen, last;
    bit gap, eopx;
    logic [1:0] eg;
    order.delete();
    for (int c = 0; c < 2; c++) begin
      opk[c] = 0; bi[c] = 0; pi[c] = 0; cnt[c] = 0;
    end
`ifdef ARB_STRICT_PRIO_EN
    a = first;
    for (int k = 0; k < np[0]; k++) order.push_back(0);
    for (int k = 0; k < np[1]; k++) order.push_back(1);
`else
    a = first;
    while (cnt[0] < np[0] || cnt[1] < np[1]) begin
      if (cnt[a] < np[a]) begin
        order.push_back(a);
        cnt[a]++;
      end
      a = 1 - a;
    end
`endif
    eidx = 0; ebeat = 0; exp_el = 0; el_seen = 0; ab_seen = 0; gap = 1'b1;
    for (int cyc = 0; cyc < 4000 && eidx < order.size(); cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if (pi[c] < np[c]) begin
          last = plen[c][pi[c]] - 1;
          drv(c, pdata[c][pi[c]][bi[c]], bi[c] == 0, bi[c] == last,
              (bi[c] == last) ? pmod[c][pi[c]] : 3'd0,
              (bi[c] == 0) || !rnd || ($urandom_range(3) != 0));
        end else begin
          drv(c, 64'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        end
      end
      tx_dst_n = rnd ? ($urandom_range(2) == 0) : ((cyc % 2) != 0);
      smp();
      own  = order[eidx];
      pk   = opk[own];
      eg   = gap ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
      eopx = 1'b0;
      chk("pk_grant", 64'(grant), 64'(eg));
      chk("pk_dst0", 64'(c0_dst_n), 64'((!gap && own == 0) ? tx_dst_n : 1'b1));
      chk("pk_dst1", 64'(c1_dst_n), 64'((!gap && own == 1) ? tx_dst_n : 1'b1));
      if (err_len) el_seen++;
      if (err_abort) ab_seen++;
      if (gap) begin
        chk("pk_idle_src", 64'(tx_src_n), 64'(1'b1));
      end else if (!tx_src_n && !tx_dst_n) begin
        chk("pk_dat", 64'(tx_dat), pdata[own][pk][ebeat]);
        chk("pk_sop", 64'(tx_sop_n), 64'(ebeat != 0));
        chk("pk_eop", 64'(tx_eop_n), 64'(ebeat != plen[own][pk] - 1));
        if (ebeat == plen[own][pk] - 1) begin
          chk("pk_mod", 64'(tx_mod), 64'(pmod[own][pk]));
          eopx = 1'b1;
        end
        ebeat++;
      end
      if (!c0_src_n && !c0_dst_n) begin
        bi[0]++;
        if (bi[0] == plen[0][pi[0]]) begin pi[0]++; bi[0] = 0; end
      end
      if (!c1_src_n && !c1_dst_n) begin
        bi[1]++;
        if (bi[1] == plen[1][pi[1]]) begin pi[1]++; bi[1] = 0; end
      end
      if (eopx) begin
        if (plen[own][pk] > MAXB) exp_el++;
        opk[own]++;
        eidx++;
        ebeat = 0;
        gap = 1'b1;
      end else begin
        gap = 1'b0;
      end
      step();
    end
    chk("pk_all_done", 64'(eidx), 64'(order.size()));
    chk("pk_errlen_cnt", 64'(el_seen), 64'(exp_el));
    chk("pk_no_abort", 64'(ab_seen), 64'd0);
    quiet();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cup = 1'b1; tx_dst_n = 1'b1;
    quiet();
    #1 rst = 1'b1;
    #2;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_tx_src", 64'(tx_src_n), 64'd1);
    chk("rst_sop_eop", 64'({tx_sop_n, tx_eop_n}), 64'd3);
    chk("rst_dst", 64'({c0_dst_n, c1_dst_n}), 64'd3);
    chk("rst_txdata", 64'(tx_dat), 64'd0);
    chk("rst_mod", 64'(tx_mod), 64'd0);
    chk("rst_errs", 64'({err_abort, err_len}), 64'd0);
    step();
    rst = 1'b0;

    // CHANNEL_UP drops on beat 3 of a 5-beat ch0 packet
    tx_dst_n = 1'b0;
    drv(0, 64'hA1, 1'b1, 1'b0, 3'd0, 1'b1);
    smp(); chk("ab_idle_gnt", 64'(grant), 64'd0);
    step();
    smp(); chk("ab_gnt", 64'(grant), 64'd1);
    chk("ab_sop", 64'(tx_sop_n), 64'd0);
    chk("ab_dat1", 64'(tx_dat), 64'hA1);
    step();
    drv(0, 64'hA2, 1'b0, 1'b0, 3'd0, 1'b1);
    smp(); chk("ab_src2", 64'(tx_src_n), 64'd0);
    step();
    drv(0, 64'hA3, 1'b0, 1'b0, 3'd0, 1'b1);
    cup = 1'b0;
    smp(); chk("ab_src_gate", 64'(tx_src_n), 64'd1);
    chk("ab_dst_gate", 64'(c0_dst_n), 64'd1);
    chk("ab_no_early", 64'(err_abort), 64'd0);
    step();
    drv(1, 64'hB1, 1'b1, 1'b0, 3'd0, 1'b1);
    smp(); chk("ab_pulse", 64'(err_abort), 64'd1);
    chk("ab_idle", 64'(grant), 64'd0);
    step();
    smp(); chk("ab_pulse_end", 64'(err_abort), 64'd0);
    chk("ab_down_nogrant", 64'(grant), 64'd0);
    step();
    cup = 1'b1;
    drv(1, 64'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    step(); step();
    smp(); chk("ab_midpkt_nogrant", 64'(grant), 64'd0);
    quiet();
    step();

    // 10-beat ch0 packet with MAX_PKT_BEATS=8
    drv(0, 64'hB01, 1'b1, 1'b0, 3'd0, 1'b1);
    smp(); chk("len_idle", 64'(grant), 64'd0);
    step();
    for (int k = 1; k <= 10; k++) begin
      drv(0, 64'hB00 + 64'(k), k == 1, k == 10, (k == 10) ? 3'd5 : 3'd0, 1'b1);
      smp();
      chk("len_gnt", 64'(grant), 64'd1);
      chk("len_dat", 64'(tx_dat), 64'hB00 + 64'(k));
      chk("len_err", 64'(err_len), 64'(k == 9));
      if (k == 10) chk("len_eop_mod", 64'({tx_eop_n, tx_mod}), 64'd5);
      step();
    end
    quiet();
    smp(); chk("len_release", 64'(grant), 64'd0);
    chk("len_err_off", 64'(err_len), 64'd0);
    step();

    // ch1 (6 beats) and ch0 (single beat) contend; tx_dst_rdy_n toggles every cycle
    np[0] = 1; plen[0][0] = 1; pdata[0][0][0] = 64'hC0C0_0001; pmod[0][0] = 3'd3;
    np[1] = 1; plen[1][0] = 6; pmod[1][0] = 3'd2;
    for (int b = 0; b < 6; b++) pdata[1][0][b] = 64'hC1C1_0000 + 64'(b);
    run_pkts(1, 1'b0);
    step();

    // asynchronous reset in the middle of a ch0 packet
    tx_dst_n = 1'b0;
    drv(0, 64'hD1, 1'b1, 1'b0, 3'd0, 1'b1);
    step();
    smp(); chk("rst_mid_gnt", 64'(grant), 64'd1);
    step();
    drv(0, 64'hD2, 1'b0, 1'b0, 3'd0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_grant", 64'(grant), 64'd0);
    chk("arst_tx_src", 64'(tx_src_n), 64'd1);
    chk("arst_dst", 64'({c0_dst_n, c1_dst_n}), 64'd3);
    chk("arst_sop_eop", 64'({tx_sop_n, tx_eop_n}), 64'd3);
    quiet();
    step();
    rst = 1'b0;
    drv(0, 64'hE1, 1'b1, 1'b1, 3'd6, 1'b1);
    drv(1, 64'hE2, 1'b1, 1'b1, 3'd0, 1'b1);
    smp(); chk("arst_rel_idle", 64'(grant), 64'd0);
    step();
    smp(); chk("arst_ch0_first", 64'(grant), 64'd1);
    // link drops in the same cycle as the single-beat EOP transfer
    cup = 1'b0;
    step();
    smp(); chk("eopdrop_no_abort", 64'(err_abort), 64'd0);
    chk("eopdrop_idle", 64'(grant), 64'd0);
    step();
    cup = 1'b1;
    quiet();
    step();

    // random packet streams from both channels after a fresh reset
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      np[c] = 10;
      for (int k = 0; k < 10; k++) begin
        plen[c][k] = int'($urandom_range(12, 1));
        pmod[c][k] = 3'($urandom_range(7));
        for (int b = 0; b < NP; b++) pdata[c][k][b] = {$urandom, $urandom};
      end
    end
    step();
    rst = 1'b0;
    run_pkts(0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
